rc4_task_scheduler: RTL and testbench

Top-level sequencer for the RC4 decryption core. For each candidate key it runs the three S-memory phases in order: init, then shuffle, then decode. It drives the 2-bit task select of the S-memory mux, issues one-cycle start pulses and waits for done from each phase engine. It steps the secret key through a brute-force range until decode reports valid plaintext or the range is exhausted.

---
 rtl/rc4_pkg.sv | 35 +++
 rtl/rc4_phase_watchdog.sv | 33 +++
 rtl/rc4_task_scheduler.sv | 143 ++++++++++++++
 tb/tb_rc4_task_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg: types and constants shared by the RC4 decryption core.
//   task_sel_t    - S-memory owner code. The scheduler drives it, and the S-memory mux decodes it.
//   sched_state_t - task scheduler state encoding. ST_ERROR exists only
//                   when RC4_SCHED_TIMEOUT_EN is defined.
//   RC4_KEY_WIDTH - default width of the secret key.
package rc4_pkg;

  localparam int RC4_KEY_WIDTH = 24;

  typedef enum logic [1:0] {
    TASK_NONE    = 2'b00,
    TASK_INIT    = 2'b01,
    TASK_SHUFFLE = 2'b10,
    TASK_DECODE  = 2'b11
  } task_sel_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_START,
    ST_INIT_WAIT,
    ST_SHUF_START,
    ST_SHUF_WAIT,
    ST_DEC_START,
    ST_DEC_WAIT,
    ST_NEXT_KEY,
    ST_FOUND,
`ifdef RC4_SCHED_TIMEOUT_EN
    ST_EXHAUSTED,
    ST_ERROR
`else
    ST_EXHAUSTED
`endif
  } sched_state_t;

endpackage

// File: rtl/rc4_phase_watchdog.sv
// rc4_phase_watchdog: per-phase cycle watchdog for the RC4 task scheduler.
// The scheduler instantiates it only when RC4_SCHED_TIMEOUT_EN is defined.
//   clk, reset_n - clock and async active-low reset
//   clear        - zero the count. The scheduler asserts it in the cycle
//                  before each wait state.
//   enable       - count this cycle. The scheduler asserts it in every wait-state cycle.
//   expired      - the current wait cycle is number TIMEOUT_CYCLES. The
//                  phase has not finished in time.
module rc4_phase_watchdog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count;

  // The count starts at 0 in the first wait cycle. Comparing against
  // TIMEOUT_CYCLES-1 therefore flags the TIMEOUT_CYCLES-th wait cycle.
  assign expired = enable && (count == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!reset_n)    count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 16'd1;
  end

endmodule

// File: rtl/rc4_task_scheduler.sv
// rc4_task_scheduler: top-level sequencer for the RC4 brute-force decryptor.
// For each candidate key it runs init -> shuffle -> decode. It steps the key
// from KEY_START to KEY_END until decode reports valid plaintext.
// Optional build macro: RC4_SCHED_TIMEOUT_EN adds a per-phase watchdog and an
// ERROR state. Without the macro, waits are unbounded and timeout_error is 0.
//   clk, reset_n            - clock, async active-low reset
//   start                   - begin a search (ignored while busy)
//   init/shuffle/decode_start - one-cycle pulses to the phase engines
//   init/shuffle/decode_done  - phase engine completion
//   decode_valid            - plaintext check, qualified by decode_done
//   select_task             - S-memory owner (task_sel_t encoding)
//   secret_key              - current candidate key
//   busy                    - search in progress
//   key_found, key_exhausted, timeout_error - sticky result flags
// All outputs are decoded from the state register or are registered. None of
// them depends on an input through combinational logic.
module rc4_task_scheduler
  import rc4_pkg::*;
#(
  parameter int                   KEY_WIDTH      = RC4_KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] KEY_START      = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_END        = KEY_WIDTH'(24'h3FFFFF),
  parameter int                   TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  output logic                 init_start,
  input  logic                 init_done,
  output logic                 shuffle_start,
  input  logic                 shuffle_done,
  output logic                 decode_start,
  input  logic                 decode_done,
  input  logic                 decode_valid,
  output logic [1:0]           select_task,
  output logic [KEY_WIDTH-1:0] secret_key,
  output logic                 busy,
  output logic                 key_found,
  output logic                 key_exhausted,
  output logic                 timeout_error
);

  sched_state_t state;
  task_sel_t    sel;

`ifdef RC4_SCHED_TIMEOUT_EN
  logic wd_clear, wd_enable, wd_expired;

  assign wd_clear  = (state == ST_INIT_START) || (state == ST_SHUF_START) ||
                     (state == ST_DEC_START);
  assign wd_enable = (state == ST_INIT_WAIT) || (state == ST_SHUF_WAIT) ||
                     (state == ST_DEC_WAIT);

  rc4_phase_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      secret_key <= KEY_START;
    end else begin
      case (state)
        // A new search always restarts from KEY_START. Leaving a terminal
        // state also clears its flag, because the flags decode from the state.
        ST_IDLE, ST_FOUND, ST_EXHAUSTED
`ifdef RC4_SCHED_TIMEOUT_EN
        , ST_ERROR
`endif
        : if (start) begin
            secret_key <= KEY_START;
            state      <= ST_INIT_START;
          end
        ST_INIT_START: state <= ST_INIT_WAIT;
        ST_INIT_WAIT:
          if (init_done) state <= ST_SHUF_START;
`ifdef RC4_SCHED_TIMEOUT_EN
          else if (wd_expired) state <= ST_ERROR;
`endif
        ST_SHUF_START: state <= ST_SHUF_WAIT;
        ST_SHUF_WAIT:
          if (shuffle_done) state <= ST_DEC_START;
`ifdef RC4_SCHED_TIMEOUT_EN
          else if (wd_expired) state <= ST_ERROR;
`endif
        ST_DEC_START: state <= ST_DEC_WAIT;
        ST_DEC_WAIT:
          if (decode_done) begin
            if (decode_valid)              state <= ST_FOUND;
            else if (secret_key == KEY_END) state <= ST_EXHAUSTED;
            else                           state <= ST_NEXT_KEY;
          end
`ifdef RC4_SCHED_TIMEOUT_EN
          else if (wd_expired) state <= ST_ERROR;
`endif
        ST_NEXT_KEY: begin
          // The key never passes KEY_END, because DEC_WAIT exits to EXHAUSTED there.
          secret_key <= secret_key + 1'b1;
          state      <= ST_INIT_START;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Moore decode of the state register. Reset forces ST_IDLE, so
  // select_task drops to TASK_NONE as soon as reset is asserted.
  always_comb begin
    // NOTE: default every combinational output first so no path infers a latch.
    sel           = TASK_NONE;
    init_start    = 1'b0;
    shuffle_start = 1'b0;
    decode_start  = 1'b0;
    busy          = 1'b1;
    key_found     = 1'b0;
    key_exhausted = 1'b0;
    timeout_error = 1'b0;
    case (state)
      ST_IDLE:       busy = 1'b0;
      ST_INIT_START: begin sel = TASK_INIT;    init_start    = 1'b1; end
      ST_INIT_WAIT:  sel = TASK_INIT;
      ST_SHUF_START: begin sel = TASK_SHUFFLE; shuffle_start = 1'b1; end
      ST_SHUF_WAIT:  sel = TASK_SHUFFLE;
      ST_DEC_START:  begin sel = TASK_DECODE;  decode_start  = 1'b1; end
      ST_DEC_WAIT:   sel = TASK_DECODE;
      ST_NEXT_KEY:   sel = TASK_NONE;
      ST_FOUND:      begin busy = 1'b0; key_found     = 1'b1; end
      ST_EXHAUSTED:  begin busy = 1'b0; key_exhausted = 1'b1; end
`ifdef RC4_SCHED_TIMEOUT_EN
      ST_ERROR:      begin busy = 1'b0; timeout_error = 1'b1; end
`endif
      default:       busy = 1'b0;
    endcase
  end

  assign select_task = sel;

endmodule

// File: tb/tb_rc4_task_scheduler.sv
// Directed testbench for rc4_task_scheduler. The DUT is built with KEY_END=3
// and TIMEOUT_CYCLES=20. Phase engines are emulated in the bench: each done
// arrives 5 cycles after its start pulse. The timeout scenario runs only when
// RC4_SCHED_TIMEOUT_EN is defined.
module tb_rc4_task_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        init_done = 1'b0, shuffle_done = 1'b0, decode_done = 1'b0;
  logic        decode_valid = 1'b0;
  logic        init_start, shuffle_start, decode_start;
  logic [1:0]  select_task;
  logic [23:0] secret_key;
  logic        busy, key_found, key_exhausted, timeout_error;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rc4_task_scheduler #(
    .KEY_WIDTH(24), .KEY_START(24'd0), .KEY_END(24'd3), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .init_start(init_start), .init_done(init_done),
    .shuffle_start(shuffle_start), .shuffle_done(shuffle_done),
    .decode_start(decode_start), .decode_done(decode_done),
    .decode_valid(decode_valid), .select_task(select_task),
    .secret_key(secret_key), .busy(busy), .key_found(key_found),
    .key_exhausted(key_exhausted), .timeout_error(timeout_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pulse_of(input int which);
    case (which)
      0:       return init_start;
      1:       return shuffle_start;
      default: return decode_start;
    endcase
  endfunction

  task automatic wait_start(input int which, input string tag);
    int n = 0;
    while (!pulse_of(which) && n < 50) begin step(); n++; end
    check(tag, {31'd0, pulse_of(which)}, 32'd1);
  endtask

  task automatic set_done(input int which, input logic v);
    case (which)
      0:       init_done = v;
      1:       shuffle_done = v;
      default: decode_done = v;
    endcase
  endtask

  // Runs one phase: checks the start pulse and the owner code, returns done
  // 5 cycles after the pulse, and ends one cycle after the done edge.
  task automatic do_phase(input int which, input logic [1:0] sel, input logic valid);
    wait_start(which, $sformatf("pulse%0d", which));
    check($sformatf("sel_at_start%0d", which), {30'd0, select_task}, {30'd0, sel});
    step();
    check($sformatf("pulse_one_cycle%0d", which), {31'd0, pulse_of(which)}, 32'd0);
    check($sformatf("sel_hold%0d", which), {30'd0, select_task}, {30'd0, sel});
    repeat (3) step();
    set_done(which, 1'b1);
    decode_valid = valid;
    step();
    set_done(which, 1'b0);
    decode_valid = 1'b0;
  endtask

  task automatic round(input logic valid);
    do_phase(0, 2'b01, 1'b0);
    do_phase(1, 2'b10, 1'b0);
    do_phase(2, 2'b11, valid);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state
    #2;
    check("rst_sel", {30'd0, select_task}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_key", {8'd0, secret_key}, 32'd0);
    check("rst_flags", {29'd0, key_found, key_exhausted, timeout_error}, 32'd0);
    check("rst_pulses", {29'd0, init_start, shuffle_start, decode_start}, 32'd0);
    #10 reset_n = 1'b1;
    repeat (3) step();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Happy path: valid on key 0. Start latency is one cycle.
    pulse_start();
    check("lat_init_start", {31'd0, init_start}, 32'd1);
    check("lat_sel", {30'd0, select_task}, 32'd1);
    round(1'b1);
    check("happy_found", {31'd0, key_found}, 32'd1);
    check("happy_key", {8'd0, secret_key}, 32'd0);
    check("happy_busy", {31'd0, busy}, 32'd0);
    check("happy_sel", {30'd0, select_task}, 32'd0);
    repeat (4) step();
    check("found_sticky", {31'd0, key_found}, 32'd1);

    // Third key valid
    pulse_start();
    check("restart_clear", {31'd0, key_found}, 32'd0);
    round(1'b0);
    check("nk_sel0", {30'd0, select_task}, 32'd0);
    check("nk_busy", {31'd0, busy}, 32'd1);
    step();
    check("key1", {8'd0, secret_key}, 32'd1);
    round(1'b0);
    check("nk_sel1", {30'd0, select_task}, 32'd0);
    round(1'b1);
    check("k2_found", {31'd0, key_found}, 32'd1);
    check("k2_key", {8'd0, secret_key}, 32'd2);

    // Exhaustion over keys 0..3
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ex_key%0d", k), {8'd0, secret_key}, k);
      round(1'b0);
      if (k < 3) step();
    end
    check("ex_flag", {31'd0, key_exhausted}, 32'd1);
    check("ex_key", {8'd0, secret_key}, 32'd3);
    check("ex_busy", {31'd0, busy}, 32'd0);
    n = 0;
    repeat (10) begin step(); n += int'(init_start) + int'(shuffle_start) + int'(decode_start); end
    check("ex_no_pulses", n, 32'd0);
    pulse_start();
    check("ex_reload_key", {8'd0, secret_key}, 32'd0);
    check("ex_clear", {31'd0, key_exhausted}, 32'd0);
    check("ex_restart", {31'd0, init_start}, 32'd1);

    // Spurious inputs during the search started above (key 0)
    do_phase(0, 2'b01, 1'b0);
    wait_start(1, "sp_shuf_start");
    shuffle_done = 1'b1;          // done is ignored in a START state
    step();
    shuffle_done = 1'b0;
    check("sp_early_done_sel", {30'd0, select_task}, 32'd2);
    check("sp_early_done_dec", {31'd0, decode_start}, 32'd0);
    start = 1'b1;                 // start is ignored while busy
    step();
    start = 1'b0;
    check("sp_start_sel", {30'd0, select_task}, 32'd2);
    check("sp_start_key", {8'd0, secret_key}, 32'd0);
    check("sp_start_init", {31'd0, init_start}, 32'd0);
    shuffle_done = 1'b1;
    step();
    shuffle_done = 1'b0;
    check("sp_dec_start", {31'd0, decode_start}, 32'd1);
    step();
    init_done = 1'b1;             // done from another phase is ignored
    step();
    init_done = 1'b0;
    check("sp_wrong_done_sel", {30'd0, select_task}, 32'd3);
    check("sp_wrong_done_pulses", {29'd0, init_start, shuffle_start, decode_start}, 32'd0);
    decode_done = 1'b1; decode_valid = 1'b1;
    step();
    decode_done = 1'b0; decode_valid = 1'b0;
    check("sp_found", {31'd0, key_found}, 32'd1);
    check("sp_key", {8'd0, secret_key}, 32'd0);

    // Reset asserted during the shuffle of key 1
    pulse_start();
    round(1'b0);
    do_phase(0, 2'b01, 1'b0);
    wait_start(1, "rs_shuf_start");
    step();
    check("rs_pre_sel", {30'd0, select_task}, 32'd2);
    check("rs_pre_key", {8'd0, secret_key}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rs_sel", {30'd0, select_task}, 32'd0);
    check("rs_busy", {31'd0, busy}, 32'd0);
    check("rs_key", {8'd0, secret_key}, 32'd0);
    #3 reset_n = 1'b1;
    n = 0;
    repeat (5) begin step(); n += int'(init_start) + int'(shuffle_start) + int'(decode_start) + int'(busy); end
    check("rs_idle", n, 32'd0);

`ifdef RC4_SCHED_TIMEOUT_EN
    // Withhold shuffle_done. The watchdog fires after 20 wait cycles.
    pulse_start();
    do_phase(0, 2'b01, 1'b0);
    wait_start(1, "to_shuf_start");
    repeat (20) step();
    check("to_not_yet", {31'd0, timeout_error}, 32'd0);
    step();
    check("to_flag", {31'd0, timeout_error}, 32'd1);
    check("to_sel", {30'd0, select_task}, 32'd0);
    check("to_busy", {31'd0, busy}, 32'd0);
    pulse_start();
    check("to_clear", {31'd0, timeout_error}, 32'd0);
    check("to_key", {8'd0, secret_key}, 32'd0);
    check("to_restart", {31'd0, init_start}, 32'd1);
`else
    check("no_timeout", {31'd0, timeout_error}, 32'd0);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
